// File: rtl/video_in_pack_fifo_if.sv
// Signal bundle between the pixel source / store stage and video_in_pack_fifo.
// ovf_count is present only when VIDEO_IN_OVF_CNT_EN is defined.
interface video_in_pack_fifo_if;
   logic [7:0]  pixel_in;
   logic        line_valid;
   logic        frame_valid;
   logic        new_addr;
   logic        r_ack;
   logic [31:0] data_fifo;
   logic        nb_pack_available;
   logic        overflow;
`ifdef VIDEO_IN_OVF_CNT_EN
   logic [15:0] ovf_count;

   modport master (
      output pixel_in, line_valid, frame_valid, new_addr, r_ack,
      input  data_fifo, nb_pack_available, overflow, ovf_count
   );
   modport slave (
      input  pixel_in, line_valid, frame_valid, new_addr, r_ack,
      output data_fifo, nb_pack_available, overflow, ovf_count
   );
`else
   modport master (
      output pixel_in, line_valid, frame_valid, new_addr, r_ack,
      input  data_fifo, nb_pack_available, overflow
   );
   modport slave (
      input  pixel_in, line_valid, frame_valid, new_addr, r_ack,
      output data_fifo, nb_pack_available, overflow
   );
`endif
endinterface

// File: rtl/video_in_pack_fifo.sv
// Captures one video frame, packs 4 pixels per 32-bit word into a show-ahead FIFO.
// Optional dropped-word counter output ovf_count enabled by macro VIDEO_IN_OVF_CNT_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | frame done or never armed; pixels ignored until new_addr
// ST_SYNC    | re-armed by new_addr; waiting for frame_valid low
// ST_ARMED   | waiting for frame_valid rise (frame start)
// ST_CAPTURE | accepting pixels on line_valid && frame_valid
module video_in_pack_fifo #(
   parameter int WIDTH   = 640,
   parameter int HEIGHT  = 480,
   parameter int NB_PACK = 16,
   parameter int DEPTH   = 32
) (
   input logic                 clk,
   input logic                 nRST,
   video_in_pack_fifo_if.slave bus
);
   localparam int              PW          = $clog2(DEPTH);
   localparam int              CW          = PW + 1;
   localparam logic [19:0]     PIX_LAST    = 20'(WIDTH * HEIGHT - 1);
   localparam logic [CW-1:0]   FULL_CNT    = CW'(DEPTH);
   localparam int unsigned     BURST_WORDS = NB_PACK / 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SYNC    = 2'd1,
      ST_ARMED   = 2'd2,
      ST_CAPTURE = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [23:0]   pack_q, pack_d;
   logic [1:0]    lane_q, lane_d;
   logic [19:0]   pix_cnt_q, pix_cnt_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic [31:0]   mem_q [DEPTH];
   logic [31:0]   mem_d [DEPTH];

   logic          accept;
   logic          last_pix;
   logic          abort;
   logic          wr_en;
   logic [31:0]   wr_word;
   logic          pop;
   logic          push;
   logic          drop;

   always_ff @(posedge clk) begin
      if (!nRST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.new_addr) begin
         state_d = ST_SYNC;
      end else begin
         case (state_q)
            ST_IDLE:    state_d = ST_IDLE;
            ST_SYNC:    if (!bus.frame_valid) state_d = ST_ARMED;
            ST_ARMED:   if (bus.frame_valid) state_d = ST_CAPTURE;
            ST_CAPTURE: begin
               if (abort) begin
                  state_d = ST_ARMED;
               end else if (last_pix) begin
                  state_d = ST_IDLE;
               end
            end
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      accept   = (state_q == ST_CAPTURE) && bus.line_valid && bus.frame_valid;
      abort    = (state_q == ST_CAPTURE) && !bus.frame_valid;
      last_pix = accept && (pix_cnt_q == PIX_LAST);
      wr_en    = accept && (lane_q == 2'd3);
      wr_word  = {bus.pixel_in, pack_q};
   end

   // Packer: the first three pixels of a word are held, the fourth goes straight to the FIFO.
   always_comb begin
      pack_d    = pack_q;
      lane_d    = lane_q;
      pix_cnt_d = pix_cnt_q;
      if (bus.new_addr || abort) begin
         pack_d    = '0;
         lane_d    = '0;
         pix_cnt_d = '0;
      end else if (accept) begin
         pix_cnt_d = pix_cnt_q + 20'd1;
         lane_d    = lane_q + 2'd1;
         case (lane_q)
            2'd0:    pack_d[7:0]   = bus.pixel_in;
            2'd1:    pack_d[15:8]  = bus.pixel_in;
            2'd2:    pack_d[23:16] = bus.pixel_in;
            default: pack_d        = '0;
         endcase
         if (last_pix) begin
            pack_d = '0;
            lane_d = '0;
         end
      end
   end

   // A pop in the same cycle frees the slot, so a write into a full FIFO is kept then.
   always_comb begin
      pop        = bus.r_ack && (count_q != '0);
      push       = wr_en && ((count_q != FULL_CNT) || pop);
      drop       = wr_en && !push;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (bus.new_addr) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
         if (drop) overflow_d = 1'b1;
      end
   end

   always_comb begin
      mem_d = mem_q;
      if (push && !bus.new_addr) mem_d[wr_ptr_q] = wr_word;
   end

   always_ff @(posedge clk) begin
      if (!nRST) begin
         pack_q     <= '0;
         lane_q     <= '0;
         pix_cnt_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         pack_q     <= pack_d;
         lane_q     <= lane_d;
         pix_cnt_q  <= pix_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage carries no reset; its content is only observed while count_q is non-zero.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

`ifdef VIDEO_IN_OVF_CNT_EN
   logic [15:0] ovf_cnt_q, ovf_cnt_d;

   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (bus.new_addr) begin
         ovf_cnt_d = '0;
      end else if (drop && (ovf_cnt_q != 16'hFFFF)) begin
         ovf_cnt_d = ovf_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!nRST) begin
         ovf_cnt_q <= '0;
      end else begin
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   assign bus.ovf_count = ovf_cnt_q;
`endif

   assign bus.data_fifo         = mem_q[rd_ptr_q];
   assign bus.nb_pack_available = (32'(count_q) >= BURST_WORDS);
   assign bus.overflow          = overflow_q;

endmodule

// File: tb/tb_video_in_pack_fifo.sv
// Bench for video_in_pack_fifo: two instances (DEPTH 8 and 2) share one stimulus stream,
// each checked every cycle against a queue-based frame model plus directed literal checks.
module tb_video_in_pack_fifo;
   localparam int W = 8;
   localparam int H = 2;
   localparam int M_IDLE      = 0;
   localparam int M_WAIT_LOW  = 1;
   localparam int M_WAIT_HIGH = 2;
   localparam int M_CAP       = 3;

   logic       clk = 1'b0;
   logic       nrst;
   logic [7:0] pix;
   logic       lv;
   logic       fv;
   logic       na;
   logic       ack;

   int tot = 0;
   int bad = 0;

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tot++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int D = (g == 0) ? 8 : 2;

      video_in_pack_fifo_if bus();
      assign bus.pixel_in    = pix;
      assign bus.line_valid  = lv;
      assign bus.frame_valid = fv;
      assign bus.new_addr    = na;
      assign bus.r_ack       = ack;

      video_in_pack_fifo #(.WIDTH(W), .HEIGHT(H), .NB_PACK(16), .DEPTH(D)) u_dut (
         .clk  (clk),
         .nRST (nrst),
         .bus  (bus)
      );

      logic [31:0] mq[$];
      int          m_mode = M_IDLE;
      logic [31:0] m_part = '0;
      logic [31:0] m_word = '0;
      int          m_nb   = 0;
      int          m_pix  = 0;
      bit          m_ovf  = 1'b0;
      int          m_ovfc = 0;
      int          m_size = 0;
      bit          m_live = 1'b0;
      bit          m_wr   = 1'b0;

      always @(posedge clk) begin
         if (!nrst || na) begin
            mq.delete();
            m_mode = nrst ? M_WAIT_LOW : M_IDLE;
            m_part = '0;
            m_nb   = 0;
            m_pix  = 0;
            m_ovf  = 1'b0;
            m_ovfc = 0;
            m_live = 1'b1;
         end else begin
            m_wr = 1'b0;
            case (m_mode)
               M_WAIT_LOW:  if (!fv) m_mode = M_WAIT_HIGH;
               M_WAIT_HIGH: if (fv) m_mode = M_CAP;
               M_CAP: begin
                  if (!fv) begin
                     m_mode = M_WAIT_HIGH;
                     m_part = '0;
                     m_nb   = 0;
                     m_pix  = 0;
                  end else if (lv) begin
                     m_part = m_part | (32'(pix) << (8 * m_nb));
                     m_nb++;
                     m_pix++;
                     if (m_nb == 4) begin
                        m_wr   = 1'b1;
                        m_word = m_part;
                        m_part = '0;
                        m_nb   = 0;
                     end
                     if (m_pix == W * H) begin
                        m_mode = M_IDLE;
                        m_part = '0;
                        m_nb   = 0;
                     end
                  end
               end
               default: ;
            endcase
            if (ack && mq.size() > 0) void'(mq.pop_front());
            if (m_wr) begin
               if (mq.size() < D) begin
                  mq.push_back(m_word);
               end else begin
                  m_ovf = 1'b1;
                  if (m_ovfc < 65535) m_ovfc++;
               end
            end
         end
         m_size = mq.size();
      end

      always @(negedge clk) begin
         if (m_live) begin
            chk($sformatf("lane%0d nb_pack_available", g), 32'(bus.nb_pack_available),
                32'(mq.size() >= 4));
            chk($sformatf("lane%0d overflow", g), 32'(bus.overflow), 32'(m_ovf));
            if (mq.size() > 0)
               chk($sformatf("lane%0d data_fifo", g), bus.data_fifo, mq[0]);
`ifdef VIDEO_IN_OVF_CNT_EN
            chk($sformatf("lane%0d ovf_count", g), 32'(bus.ovf_count), 32'(m_ovfc));
`endif
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic new_frame();
      na = 1'b1;
      step(1);
      na = 1'b0;
      fv = 1'b0;
      step(1);
      fv = 1'b1;
      step(2);
   endtask

   task automatic send(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         pix = base + 8'(i);
         lv  = 1'b1;
         step(1);
      end
      lv = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ew [4];
      ew[0] = 32'h04030201;
      ew[1] = 32'h08070605;
      ew[2] = 32'h0C0B0A09;
      ew[3] = 32'h100F0E0D;
      nrst = 1'b0; pix = '0; lv = 1'b0; fv = 1'b0; na = 1'b0; ack = 1'b0;
      step(3);
      chk("reset nb_pack", 32'(lane[0].bus.nb_pack_available), 32'd0);
      chk("reset overflow", 32'(lane[0].bus.overflow), 32'd0);
      nrst = 1'b1;
      step(1);

      // packing and burst threshold
      new_frame();
      send(8'h01, 4);
      chk("pack word lane0", lane[0].bus.data_fifo, 32'h04030201);
      chk("pack word lane1", lane[1].bus.data_fifo, 32'h04030201);
      send(8'h05, 8);
      chk("burst below threshold", 32'(lane[0].bus.nb_pack_available), 32'd0);
      send(8'h0D, 4);
      chk("burst reached", 32'(lane[0].bus.nb_pack_available), 32'd1);
      chk("model size 4", 32'(lane[0].m_size), 32'd4);

      // frame end: further pixels ignored
      send(8'h20, 8);
      chk("frame end size", 32'(lane[0].m_size), 32'd4);
      chk("frame end head", lane[0].bus.data_fifo, 32'h04030201);
      chk("shallow overflow", 32'(lane[1].bus.overflow), 32'd1);
      chk("shallow size", 32'(lane[1].m_size), 32'd2);
`ifdef VIDEO_IN_OVF_CNT_EN
      chk("shallow ovf_count", 32'(lane[1].bus.ovf_count), 32'd2);
`endif
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("read order %0d", i), lane[0].bus.data_fifo, ew[i]);
         ack = 1'b1;
         step(1);
         ack = 1'b0;
         if (i == 0) chk("burst falls", 32'(lane[0].bus.nb_pack_available), 32'd0);
      end
      chk("drained", 32'(lane[0].m_size), 32'd0);

      // full FIFO with same-cycle pop and write
      new_frame();
      send(8'h01, 8);
      chk("full no ovf", 32'(lane[1].bus.overflow), 32'd0);
      send(8'h09, 3);
      pix = 8'h0C; lv = 1'b1; ack = 1'b1;
      step(1);
      lv = 1'b0; ack = 1'b0;
      chk("pop+write no drop", 32'(lane[1].bus.overflow), 32'd0);
      chk("pop+write head", lane[1].bus.data_fifo, 32'h08070605);
      chk("pop+write size", 32'(lane[1].m_size), 32'd2);

      // flush mid-frame with 3 words stored
      new_frame();
      send(8'h01, 12);
      chk("pre-flush overflow", 32'(lane[1].bus.overflow), 32'd1);
      na = 1'b1;
      step(1);
      na = 1'b0;
      chk("flush nb_pack", 32'(lane[0].bus.nb_pack_available), 32'd0);
      chk("flush overflow", 32'(lane[1].bus.overflow), 32'd0);
      chk("flush size", 32'(lane[0].m_size), 32'd0);
      send(8'h40, 4);
      chk("held off size", 32'(lane[0].m_size), 32'd0);

      // pop on empty
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      chk("empty pop overflow", 32'(lane[0].bus.overflow), 32'd0);
      fv = 1'b0;
      step(1);
      fv = 1'b1;
      step(2);
      send(8'h50, 4);
      chk("rearm head lane0", lane[0].bus.data_fifo, 32'h53525150);
      chk("rearm head lane1", lane[1].bus.data_fifo, 32'h53525150);

      // short frame: 6 pixels then frame_valid drops
      send(8'h60, 2);
      fv = 1'b0;
      step(1);
      chk("short frame size", 32'(lane[0].m_size), 32'd1);
      fv = 1'b1;
      step(2);
      send(8'h70, 4);
      chk("after abort head", lane[0].bus.data_fifo, 32'h53525150);
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      chk("partial discarded", lane[0].bus.data_fifo, 32'h73727170);
      ack = 1'b1;
      step(1);
      ack = 1'b0;

      // reset mid-frame
      send(8'h78, 2);
      nrst = 1'b0;
      step(2);
      nrst = 1'b1;
      send(8'h80, 8);
      chk("post reset size", 32'(lane[0].m_size), 32'd0);
      chk("post reset nb_pack", 32'(lane[0].bus.nb_pack_available), 32'd0);
      new_frame();
      send(8'h90, 4);
      chk("post reset capture", lane[0].bus.data_fifo, 32'h93929190);
      step(2);

      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end
endmodule

// File: doc/video_in_pack_fifo.md
VIDEO_IN_PACK_FIFO -- requirements
Module: video_in_pack_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 640, pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 480, lines per frame.
REQ-003 SHALL have parameter NB_PACK, default 16, pixels per burst; must be a multiple of 4.
REQ-004 SHALL have parameter DEPTH, default 32, FIFO depth in 32-bit words; must be a power of 2 and at least NB_PACK/4.
REQ-005 SHALL have one clock; reset is synchronous and active-low. Ports: clk input 1, the single clock; nRST input 1, synchronous active-low reset.
REQ-006 SHALL have pixel_in input 8, pixel value from the video source.
REQ-007 SHALL have line_valid input 1, active line qualifier.
REQ-008 SHALL have frame_valid input 1, active frame qualifier.
REQ-009 SHALL have new_addr input 1, one-cycle pulse from the store stage: flush and re-arm.
REQ-010 SHALL have r_ack input 1, pop of the head word.
REQ-011 SHALL have data_fifo output 32, head word (show-ahead).
REQ-012 SHALL have nb_pack_available output 1, at least NB_PACK/4 words stored.
REQ-013 SHALL have overflow output 1, sticky flag: a word was dropped.

Function
REQ-014 SHALL use the state machine IDLE -> SYNC -> ARMED -> CAPTURE -> IDLE.
- IDLE -> SYNC on new_addr.
- SYNC -> ARMED when frame_valid==0.
- ARMED -> CAPTURE when frame_valid==1.
REQ-015 SHALL, in CAPTURE only, accept pixel_in on each cycle with line_valid&&frame_valid; pixels outside CAPTURE are ignored.
REQ-016 SHALL pack 4 accepted pixels little-endian: 1st pixel [7:0], 2nd [15:8], 3rd [23:16], 4th [31:24].
REQ-017 SHALL write the packed word into the FIFO in the cycle after the 4th pixel is accepted (1-cycle latency).
REQ-018 SHALL count accepted pixels with a 20-bit counter; after WIDTH*HEIGHT pixels, go CAPTURE -> IDLE and ignore further pixels.
REQ-019 SHALL, if frame_valid falls in CAPTURE before WIDTH*HEIGHT pixels, discard any partial word and return to ARMED (wait for the next frame start); words already stored are kept.
REQ-020 SHALL, on new_addr in any state, do all of the following in the next cycle: empty the FIFO, clear the packer, pixel counter and overflow, and enter SYNC; new_addr has priority over a same-cycle write or pop.
REQ-021 SHALL, on r_ack with FIFO non-empty, advance the read pointer; data_fifo shows the next word the following cycle.
REQ-022 SHALL ignore r_ack on an empty FIFO: no pointer change and no error.
REQ-023 SHALL hold data_fifo stable while the FIFO is non-empty and no pop occurs; its value is don't-care when empty.
REQ-024 SHALL, on a write when full, drop the word and set overflow; a same-cycle pop frees the slot first, so the write is accepted.
REQ-025 SHALL, on a simultaneous write and pop when not full, leave the word count unchanged.
REQ-026 SHALL drive nb_pack_available = (count >= NB_PACK/4), decoded from registered count with no combinational path from r_ack.
REQ-027 SHALL use pointers of width log2(DEPTH) that wrap modulo DEPTH, and a count of width log2(DEPTH)+1.

Reset
REQ-028 SHALL, on nRST==0 at a clk edge, enter state IDLE, set the FIFO empty, clear packer and counter, and drive nb_pack_available=0 and overflow=0; data_fifo is don't-care.
REQ-029 SHALL, when reset occurs mid-frame, discard all data; capture resumes only after new_addr and a full frame start.

Configuration
REQ-030 SHALL, with macro VIDEO_IN_OVF_CNT_EN defined, add output ovf_count (output, 16 bits): dropped-word count, saturating at 16'hFFFF, cleared by reset and new_addr.
REQ-031 SHALL, without VIDEO_IN_OVF_CNT_EN, omit the port and counter; overflow behaviour is unchanged.

Verification
Bench parameters: WIDTH=8, HEIGHT=2, NB_PACK=16, DEPTH=8.
REQ-032 SHALL cover packing: new_addr, frame_valid 0->1, pixels 0x01..0x04 -> data_fifo=0x04030201 one cycle after the 4th pixel.
REQ-033 SHALL cover the burst threshold: 16 pixels with no r_ack -> nb_pack_available rises after the 4th word; 4 r_ack pops -> falls, and words read in order.
REQ-034 SHALL cover the frame end: 16 pixels, then frame_valid held high with 8 more valid pixels -> exactly 4 words stored and state IDLE.
REQ-035 SHALL cover overflow: DEPTH=2, 16 pixels with no pops -> 2 words stored, overflow=1, ovf_count=2 (macro on); a full FIFO with a same-cycle pop and write -> no drop.
REQ-036 SHALL cover flush: new_addr mid-frame with 3 words stored -> next cycle count=0, nb_pack_available=0, overflow=0, and data held off until the next frame_valid rise.
REQ-037 SHALL cover an empty pop and a short frame: r_ack on an empty FIFO -> no change; frame_valid dropped after 6 pixels -> 1 word kept, partial word discarded, state ARMED.
